// File: rtl/alu_issue_32i.sv
// RV32I execute-stage issue register: decodes ALU-class instructions into an
// operation code plus pre-conditioned operands, held in a valid/ready stage.
module alu_issue_32i #(
    parameter int DATA_WIDTH = 32,
    parameter int OPER_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [31:0]           instr_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [OPER_WIDTH-1:0] oper_o,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic [DATA_WIDTH-1:0] b_o,
    output logic [4:0]            rd_o,
    output logic                  we_o,
    output logic                  illegal_o
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [OPER_WIDTH-1:0] ALU_ADD = OPER_WIDTH'(0);
    localparam logic [OPER_WIDTH-1:0] ALU_SUB = OPER_WIDTH'(1);
    localparam logic [OPER_WIDTH-1:0] ALU_AND = OPER_WIDTH'(2);
    localparam logic [OPER_WIDTH-1:0] ALU_OR  = OPER_WIDTH'(3);
    localparam logic [OPER_WIDTH-1:0] ALU_XOR = OPER_WIDTH'(4);
    localparam logic [OPER_WIDTH-1:0] ALU_SLL = OPER_WIDTH'(5);
    localparam logic [OPER_WIDTH-1:0] ALU_SRL = OPER_WIDTH'(6);
    localparam logic [OPER_WIDTH-1:0] ALU_SRA = OPER_WIDTH'(7);
    localparam logic [OPER_WIDTH-1:0] ALU_GT  = OPER_WIDTH'(8);

    localparam logic [DATA_WIDTH-1:0] SIGN_BIAS = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic                  is_imm;
    logic                  f7_base_ok;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_u;
    logic [DATA_WIDTH-1:0] shamt;
    logic [DATA_WIDTH-1:0] src2;

    logic [OPER_WIDTH-1:0] dec_oper;
    logic [DATA_WIDTH-1:0] dec_a;
    logic [DATA_WIDTH-1:0] dec_b;
    logic                  dec_legal;

    logic                  valid_reg;
    logic [OPER_WIDTH-1:0] oper_reg;
    logic [DATA_WIDTH-1:0] a_reg;
    logic [DATA_WIDTH-1:0] b_reg;
    logic [4:0]            rd_reg;
    logic                  we_reg;
    logic                  illegal_reg;
    logic                  in_fire;

    assign opcode     = instr_i[6:0];
    assign funct3     = instr_i[14:12];
    assign funct7     = instr_i[31:25];
    assign is_imm     = (opcode == OPC_OPIMM);
    // Immediate forms carry immediate bits in funct7, so only register forms check it.
    assign f7_base_ok = is_imm || (funct7 == F7_BASE);
    assign imm_i      = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
    assign imm_u      = DATA_WIDTH'({instr_i[31:12], 12'b0});
    assign shamt      = DATA_WIDTH'(instr_i[24:20]);
    assign src2       = is_imm ? imm_i : rs2_data_i;

    always_comb begin
        dec_oper  = ALU_ADD;
        dec_a     = '0;
        dec_b     = '0;
        dec_legal = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec_legal = 1'b1;
                dec_b     = imm_u;
            end
            OPC_AUIPC: begin
                dec_legal = 1'b1;
                dec_a     = pc_i;
                dec_b     = imm_u;
            end
            OPC_OP, OPC_OPIMM: begin
                dec_a = rs1_data_i;
                dec_b = src2;
                case (funct3)
                    3'b000: begin
                        dec_legal = f7_base_ok || (funct7 == F7_ALT);
                        dec_oper  = (!is_imm && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    end
                    3'b001: begin
                        dec_legal = (funct7 == F7_BASE);
                        dec_oper  = ALU_SLL;
                        if (is_imm) dec_b = shamt;
                    end
                    3'b010, 3'b011: begin
                        // Swapped operands turn "a > b" into "rs1 < src2"; the
                        // sign bias makes the unsigned compare act signed for slt.
                        dec_legal = f7_base_ok;
                        dec_oper  = ALU_GT;
                        dec_a     = (funct3 == 3'b010) ? (src2 ^ SIGN_BIAS) : src2;
                        dec_b     = (funct3 == 3'b010) ? (rs1_data_i ^ SIGN_BIAS) : rs1_data_i;
                    end
                    3'b100: begin
                        dec_legal = f7_base_ok;
                        dec_oper  = ALU_XOR;
                    end
                    3'b101: begin
                        dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                        dec_oper  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        if (is_imm) dec_b = shamt;
                    end
                    3'b110: begin
                        dec_legal = f7_base_ok;
                        dec_oper  = ALU_OR;
                    end
                    default: begin
                        dec_legal = f7_base_ok;
                        dec_oper  = ALU_AND;
                    end
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
        if (!dec_legal) begin
            dec_oper = ALU_ADD;
            dec_a    = '0;
            dec_b    = '0;
        end
    end

    assign in_ready_o = !valid_reg || out_ready_i;
    assign in_fire    = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_reg   <= 1'b0;
            oper_reg    <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            rd_reg      <= '0;
            we_reg      <= 1'b0;
            illegal_reg <= 1'b0;
        end else if (flush_i) begin
            valid_reg <= 1'b0;
        end else if (in_fire) begin
            valid_reg   <= 1'b1;
            oper_reg    <= dec_oper;
            a_reg       <= dec_a;
            b_reg       <= dec_b;
            rd_reg      <= instr_i[11:7];
            we_reg      <= dec_legal && (instr_i[11:7] != 5'd0);
            illegal_reg <= !dec_legal;
        end else if (out_ready_i) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid_o = valid_reg;
    assign oper_o      = oper_reg;
    assign a_o         = a_reg;
    assign b_o         = b_reg;
    assign rd_o        = rd_reg;
    assign we_o        = we_reg;
    assign illegal_o   = illegal_reg;

endmodule

// File: tb/tb_alu_issue_32i.sv
// Bench for alu_issue_32i: instruction-level reference model compared every
// cycle, plus directed literal expectations and randomized traffic.
module tb_alu_issue_32i;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  oper;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;

    alu_issue_32i #(.DATA_WIDTH(32), .OPER_WIDTH(4)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .instr_i(instr), .pc_i(pc), .rs1_data_i(rs1), .rs2_data_i(rs2),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .oper_o(oper), .a_o(a), .b_o(b), .rd_o(rd), .we_o(we), .illegal_o(illegal)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0]  oper;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } dec_t;

    // Instruction semantics: "a > b" compare realises set-less-than with swapped operands.
    function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                        input logic [31:0] r1, input logic [31:0] r2);
        dec_t d;
        logic [6:0] op;
        logic [6:0] f7;
        logic [31:0] imm;
        logic [31:0] y;
        logic imm_form;
        logic ok;
        logic [3:0] code;
        logic [31:0] x;
        logic [31:0] z;
        op = ins[6:0];
        f7 = ins[31:25];
        imm = {{20{ins[31]}}, ins[31:20]};
        imm_form = (op == 7'b0010011);
        y = imm_form ? imm : r2;
        ok = 1'b0; code = 4'd0; x = 32'd0; z = 32'd0;
        if (op == 7'b0110111) begin
            ok = 1'b1; z = {ins[31:12], 12'h000};
        end else if (op == 7'b0010111) begin
            ok = 1'b1; x = p; z = {ins[31:12], 12'h000};
        end else if (op == 7'b0110011 || imm_form) begin
            x = r1; z = y;
            case (ins[14:12])
                3'd0: begin
                    if (imm_form)            begin ok = 1; code = 0; end
                    else if (f7 == 7'h00)    begin ok = 1; code = 0; end
                    else if (f7 == 7'h20)    begin ok = 1; code = 1; end
                end
                3'd1: begin ok = (f7 == 7'h00); code = 5; if (imm_form) z = {27'd0, ins[24:20]}; end
                3'd2: begin ok = imm_form || f7 == 0; code = 8;
                            x = y + 32'h8000_0000; z = r1 + 32'h8000_0000; end
                3'd3: begin ok = imm_form || f7 == 0; code = 8; x = y; z = r1; end
                3'd4: begin ok = imm_form || f7 == 0; code = 4; end
                3'd5: begin ok = (f7 == 7'h00) || (f7 == 7'h20); code = (f7 == 7'h20) ? 4'd7 : 4'd6;
                            if (imm_form) z = {27'd0, ins[24:20]}; end
                3'd6: begin ok = imm_form || f7 == 0; code = 3; end
                default: begin ok = imm_form || f7 == 0; code = 2; end
            endcase
        end
        d.rd = ins[11:7];
        d.ill = !ok;
        d.we = ok && (ins[11:7] != 5'd0);
        d.oper = ok ? code : 4'd0;
        d.a = ok ? x : 32'd0;
        d.b = ok ? z : 32'd0;
        return d;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference stage: one held instruction, replaced or drained by the handshake rules.
    dec_t m;
    logic m_valid = 1'b0;
    logic chk_en = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0;
            m = '0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m = ref_decode(instr, pc, rs1, rs2);
            m_valid = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    end

    logic [4:0] out_q[$];
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("out_valid", out_valid, m_valid);
            check("in_ready", in_ready, !m_valid || out_ready);
            check("oper", oper, m.oper);
            check("a", a, m.a);
            check("b", b, m.b);
            check("rd", rd, m.rd);
            check("we", we, m.we);
            check("illegal", illegal, m.ill);
            if (out_valid && out_ready) begin
                out_q.push_back(rd);
                $display("xfer rd=%0d oper=%0d a=%h b=%h we=%0d ill=%0d", rd, oper, a, b, we, illegal);
            end
        end
    end

    task automatic issue(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        instr = ins; rs1 = r1; rs2 = r2; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(negedge clk); #1;
    endtask

    function automatic logic [31:0] rand_instr();
        int k;
        logic [31:0] w;
        k = $urandom_range(0, 9);
        w = $urandom();
        case (k)
            0, 1, 2: begin
                w[6:0] = 7'b0110011;
                if ($urandom_range(0, 3) != 0) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            end
            3, 4, 5: begin
                w[6:0] = 7'b0010011;
                if ($urandom_range(0, 1) != 0) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            end
            6: w[6:0] = 7'b0110111;
            7: w[6:0] = 7'b0010111;
            default: ;
        endcase
        return w;
    endfunction

    logic [31:0] stream[4];
    int k;
    logic acc;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = 32'd0; pc = 32'd0; rs1 = 32'd0; rs2 = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_data", {oper, rd, we, illegal}, 0);
        check("rst_ab", a | b, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        chk_en = 1'b1;

        // Directed literal expectations
        issue(32'h002081B3, 32'd5, 32'd7);
        check("add_valid", out_valid, 1); check("add_oper", oper, 0);
        check("add_a", a, 5); check("add_b", b, 7); check("add_rd", rd, 3); check("add_we", we, 1);
        issue(32'h402081B3, 32'd5, 32'd7);
        check("sub_oper", oper, 1);
        issue(32'h0020A1B3, 32'hFFFFFFFF, 32'd1);
        check("slt_oper", oper, 8); check("slt_a", a, 32'h80000001); check("slt_b", b, 32'h7FFFFFFF);
        issue(32'h0020B1B3, 32'hFFFFFFFF, 32'd1);
        check("sltu_a", a, 32'd1); check("sltu_b", b, 32'hFFFFFFFF);
        issue(32'h123452B7, 32'd9, 32'd9);
        check("lui_oper", oper, 0); check("lui_a", a, 0); check("lui_b", b, 32'h12345000); check("lui_rd", rd, 5);
        issue(32'hFFF00013, 32'd0, 32'd0);
        check("addi_x0_b", b, 32'hFFFFFFFF); check("addi_x0_we", we, 0);
        issue(32'h4030D093, 32'h80000000, 32'd0);
        check("srai_oper", oper, 7); check("srai_b", b, 3);
        issue(32'hFFFFFFFF, 32'd1, 32'd2);
        check("illegal_flag", illegal, 1); check("illegal_we", we, 0); check("illegal_oper", oper, 0);
        check("illegal_ab", a | b, 0);

        // Four-instruction stream with downstream stalled in cycles 2-3
        @(posedge clk); #2;
        out_q.delete();
        stream[0] = 32'h002081B3; stream[1] = 32'h402080B3;
        stream[2] = 32'h123452B7; stream[3] = 32'h00108493;
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            instr = stream[k]; rs1 = 32'd100 + c; rs2 = 32'd3; in_valid = 1'b1;
            out_ready = !(c == 2 || c == 3);
            #1;
            if (c == 2 || c == 3) check("stall_in_ready", in_ready, 0);
            acc = in_ready;
            @(posedge clk); #2;
            if (acc) k++;
        end
        check("stream_accepted", k, 4);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("stream_count", out_q.size(), 4);
        if (out_q.size() == 4) begin
            check("stream_rd0", out_q[0], 3); check("stream_rd1", out_q[1], 1);
            check("stream_rd2", out_q[2], 5); check("stream_rd3", out_q[3], 9);
        end

        // Flush discards both the held and the same-cycle incoming instruction
        instr = 32'h002081B3; rs1 = 32'd1; rs2 = 32'd2; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #2;
        instr = 32'h123452B7; flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0; in_valid = 1'b0; #1;
        check("flush_valid", out_valid, 0);
        check("flush_keeps_rd", rd, 3);
        instr = 32'h00108393; rs1 = 32'd4; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0; #1;
        check("post_flush_valid", out_valid, 1);
        check("post_flush_rd", rd, 7);
        check("post_flush_a", a, 4);

        // Asynchronous reset in the middle of a stall
        instr = 32'h402081B3; rs1 = 32'd50; rs2 = 32'd8; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #2;
        in_valid = 1'b0; #1;
        rst = 1'b1; #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", {oper, rd, we, illegal}, 0);
        check("arst_ab", a | b, 0);
        check("arst_in_ready", in_ready, 1);
        @(posedge clk); #2;
        rst = 1'b0;

        // Randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            instr = rand_instr();
            pc = $urandom(); rs1 = $urandom(); rs2 = $urandom();
            if ($urandom_range(0, 7) == 0) rs1 = 32'h80000000;
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 19) == 0);
            @(posedge clk); #2;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
